// File: rtl/display_reader.sv
// Watches a 7-segment bus, accepts a pattern once it has been stable for STABLE_CYCLES samples,
// decodes it to a user code and queues {error, blank, code} events in a 4-entry FIFO.
module display_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] segments_in,
  output logic [2:0] code_out,
  output logic       blank_out,
  output logic       error_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       overflow
);

  typedef enum logic {TRACK, HOLD} state_t;

  localparam logic [3:0] STABLE    = 4'(STABLE_CYCLES);
  localparam logic [6:0] BLANK_PAT = 7'h7F;

  state_t     state_reg;
  logic [6:0] cand_reg;
  logic [6:0] last_reg;
  logic [3:0] cnt_reg;
  logic [3:0] cnt_next;
  logic       same;
  logic       update;
  logic       reached;
  logic       push;
  logic [4:0] entry;

  logic [4:0] mem [4];
  logic [1:0] wr_ptr_reg;
  logic [1:0] rd_ptr_reg;
  logic [2:0] count_reg;
  logic       full;
  logic       pop;
  logic       write;
  logic [4:0] head;

  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40:   decode = {2'b00, 3'd0};
      7'h30:   decode = {2'b00, 3'd1};
      7'h24:   decode = {2'b00, 3'd3};
      7'h79:   decode = {2'b00, 3'd5};
      7'h19:   decode = {2'b00, 3'd6};
      7'h7F:   decode = {2'b01, 3'd0};
      default: decode = {2'b10, 3'd0};
    endcase
  endfunction

  // A HOLD with an unchanged bus is the only case where nothing moves; a change out of HOLD
  // restarts at 1 so that STABLE_CYCLES=1 still accepts on the very first sample.
  always_comb begin
    same     = (segments_in == cand_reg);
    update   = !(state_reg == HOLD && same);
    cnt_next = same ? cnt_reg + 4'd1 : 4'd1;
    reached  = update && (cnt_next == STABLE);
    push     = reached && (segments_in != last_reg);
    entry    = decode(segments_in);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= TRACK;
      cand_reg  <= BLANK_PAT;
      last_reg  <= BLANK_PAT;
      cnt_reg   <= 4'd0;
    end else if (update) begin
      cand_reg <= segments_in;
      cnt_reg  <= cnt_next;
      if (reached) begin
        state_reg <= HOLD;
        if (push) last_reg <= segments_in;
      end else begin
        state_reg <= TRACK;
      end
    end
  end

  always_comb begin
    code_valid = (count_reg != 3'd0);
    full       = (count_reg == 3'd4);
    pop        = code_valid && code_ready;
    // When full, a simultaneous pop frees the slot the write pointer is aimed at.
    write      = push && (!full || pop);
    head       = code_valid ? mem[rd_ptr_reg] : 5'd0;
    code_out   = head[2:0];
    blank_out  = head[3];
    error_out  = head[4];
  end

  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr_reg] <= entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
      overflow   <= 1'b0;
    end else begin
      if (write) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 2'd1;
      count_reg <= count_reg + 3'(write) - 3'(pop);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display_reader.sv
// Randomised and directed bench for display_reader against a run-length based reference model.
module tb_display_reader;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] segments_in = 7'h7F;
  logic [2:0] code_out;
  logic       blank_out;
  logic       error_out;
  logic       code_valid;
  logic       code_ready = 1'b0;
  logic       overflow;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: length of the current run of identical samples, last accepted pattern,
  // and the expected queue contents.
  logic [6:0] run_val;
  int         run_len;
  logic [6:0] last_acc;
  logic [4:0] exp_q[$];
  logic       exp_ovf;

  display_reader #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk),
    .reset(reset),
    .segments_in(segments_in),
    .code_out(code_out),
    .blank_out(blank_out),
    .error_out(error_out),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    case (p)
      7'h40:   return 5'd0;
      7'h30:   return 5'd1;
      7'h24:   return 5'd3;
      7'h79:   return 5'd5;
      7'h19:   return 5'd6;
      7'h7F:   return 5'b01000;
      default: return 5'b10000;
    endcase
  endfunction

  function automatic logic [31:0] head_of(input logic [2:0] c, input logic b, input logic e);
    return 32'({e, b, c});
  endfunction

  task automatic model_reset();
    run_val  = 7'h7F;
    run_len  = 0;
    last_acc = 7'h7F;
    exp_q.delete();
    exp_ovf  = 1'b0;
  endtask

  // Drive one sample and advance the model by the edge that will sample it.
  task automatic drive(input logic [6:0] seg, input logic rdy);
    bit pop_m;
    bit push_m;
    bit full_m;
    segments_in = seg;
    code_ready  = rdy;
    pop_m  = (exp_q.size() > 0) && rdy;
    full_m = (exp_q.size() == 4);
    if (seg == run_val) run_len++;
    else begin
      run_val = seg;
      run_len = 1;
    end
    push_m = (run_len == STABLE) && (seg != last_acc);
    if (pop_m) void'(exp_q.pop_front());
    if (push_m) begin
      last_acc = seg;
      if (full_m && !pop_m) exp_ovf = 1'b1;
      else exp_q.push_back(ref_decode(seg));
    end
    $display("[TB] t=%0t seg=%02h rdy=%0b push=%0b pop=%0b depth=%0d", $time, seg, rdy, push_m, pop_m, exp_q.size());
  endtask

  task automatic cycle(input logic [6:0] seg, input logic rdy);
    @(negedge clk);
    chk("valid", 32'(code_valid), 32'(exp_q.size() > 0));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    if (exp_q.size() > 0) chk("head", head_of(code_out, blank_out, error_out), 32'(exp_q[0]));
    drive(seg, rdy);
  endtask

  task automatic hold(input logic [6:0] seg, input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(seg, rdy);
  endtask

  task automatic do_reset(input logic [6:0] seg, input logic rdy);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_valid", 32'(code_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_head", head_of(code_out, blank_out, error_out), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(seg, rdy);
  endtask

  logic [6:0] pats [8];

  initial begin
    pats[0] = 7'h40; pats[1] = 7'h30; pats[2] = 7'h24; pats[3] = 7'h79;
    pats[4] = 7'h19; pats[5] = 7'h7F; pats[6] = 7'h00; pats[7] = 7'h12;
    model_reset();

    // Blank bus after reset produces nothing.
    do_reset(7'h7F, 1'b1);
    hold(7'h7F, 8, 1'b1);

    // Single event, valid for one cycle with ready high.
    hold(7'h40, 4, 1'b1);
    hold(7'h40, 3, 1'b1);

    // Glitch restarts the count.
    hold(7'h30, 2, 1'b1);
    hold(7'h24, 1, 1'b1);
    hold(7'h30, 6, 1'b1);

    // Code, blank, error in order.
    hold(7'h79, 5, 1'b1);
    hold(7'h7F, 5, 1'b1);
    hold(7'h00, 5, 1'b1);
    hold(7'h00, 3, 1'b1);

    // Overflow with consumer stalled, then drain.
    hold(7'h40, 5, 1'b0);
    hold(7'h30, 5, 1'b0);
    hold(7'h24, 5, 1'b0);
    hold(7'h79, 5, 1'b0);
    hold(7'h19, 5, 1'b0);
    hold(7'h19, 6, 1'b1);

    // Full FIFO, fifth push coincides with a pop.
    do_reset(7'h40, 1'b0);
    hold(7'h40, 3, 1'b0);
    hold(7'h30, 4, 1'b0);
    hold(7'h24, 4, 1'b0);
    hold(7'h79, 4, 1'b0);
    hold(7'h19, 3, 1'b0);
    hold(7'h19, 7, 1'b1);

    // Reset mid-count with entries queued.
    hold(7'h40, 4, 1'b0);
    hold(7'h30, 4, 1'b0);
    hold(7'h19, 3, 1'b0);
    do_reset(7'h19, 1'b1);
    hold(7'h19, 3, 1'b1);
    hold(7'h19, 4, 1'b1);

    // Random segments, hold lengths and back-pressure, with occasional resets.
    for (int n = 0; n < 300; n++) begin
      logic [6:0] p;
      int len;
      p   = pats[$urandom_range(7)];
      len = $urandom_range(7, 1);
      if ($urandom_range(49) == 0) do_reset(p, 1'b1);
      for (int k = 0; k < len; k++) cycle(p, ($urandom_range(3) != 0));
    end
    hold(7'h7F, 12, 1'b1);
    @(negedge clk);
    chk("final_valid", 32'(code_valid), 32'(exp_q.size() > 0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
